miim_arbiter: RTL

//  Shares one MIIM management master (MDC/MDIO engine) between NREQ requesters.

---
 rtl/miim_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/miim_arbiter.sv
// Round-robin arbiter sharing one MIIM (MDC/MDIO) master between NREQ requesters.
// Define MIIM_ARB_PRIO_EN to give requester 0 fixed highest priority over a rotating 1..NREQ-1.
module miim_arbiter #(
    parameter int NREQ      = 3,
    parameter int BUSY_WAIT = 4,
    parameter int TIMEOUT   = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [5*NREQ-1:0]    req_phyad,
    input  logic [5*NREQ-1:0]    req_regad,
    input  logic [16*NREQ-1:0]   req_wrdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_err,
    output logic [15:0]          rsp_rddata,
    output logic [4:0]           miim_phyad,
    output logic [4:0]           miim_regad,
    output logic [15:0]          miim_wrdata,
    output logic                 miim_wren,
    output logic                 miim_rden,
    input  logic                 miim_busy,
    input  logic [15:0]          miim_rddata
);

    localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (BUSY_WAIT > TIMEOUT) ? BUSY_WAIT : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [NREQ-1:0] ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          state;
    logic [LW-1:0]   last_grant;
    logic [LW-1:0]   win_q;
    logic            wr_q;
    logic            err_q;
    logic [4:0]      phyad_q;
    logic [4:0]      regad_q;
    logic [15:0]     wrdata_q;
    logic [CW-1:0]   cnt;

    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [4:0]      sel_phyad;
    logic [4:0]      sel_regad;
    logic [15:0]     sel_wrdata;

    // Search starts one past the last grant so every requester gets its turn.
    always_comb begin
        int  idx;
        logic cand;
        // NOTE: every combinational output gets a default first; otherwise paths that skip an assignment infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NREQ) idx = idx - NREQ;
`ifdef MIIM_ARB_PRIO_EN
            cand = (idx != 0);
`else
            cand = 1'b1;
`endif
            if (!win_found && cand && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = LW'(idx);
            end
        end
`ifdef MIIM_ARB_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
        sel_phyad  = req_phyad[5*int'(win_idx) +: 5];
        sel_regad  = req_regad[5*int'(win_idx) +: 5];
        sel_wrdata = req_wrdata[16*int'(win_idx) +: 16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= LW'(NREQ - 1);
            win_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            phyad_q     <= '0;
            regad_q     <= '0;
            wrdata_q    <= '0;
            cnt         <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rsp_rddata  <= '0;
            miim_phyad  <= '0;
            miim_regad  <= '0;
            miim_wrdata <= '0;
            miim_wren   <= 1'b0;
            miim_rden   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_rddata <= '0;
            miim_wren  <= 1'b0;
            miim_rden  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A master still busy from an op cut short by reset blocks new grants.
                    if (!miim_busy && win_found) begin
                        req_ready <= ONE << win_idx;
                        win_q     <= win_idx;
                        wr_q      <= req_wr[win_idx];
                        phyad_q   <= sel_phyad;
                        regad_q   <= sel_regad;
                        wrdata_q  <= sel_wrdata;
`ifdef MIIM_ARB_PRIO_EN
                        if (win_idx != '0) last_grant <= win_idx;
`else
                        last_grant <= win_idx;
`endif
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    miim_phyad  <= phyad_q;
                    miim_regad  <= regad_q;
                    miim_wrdata <= wrdata_q;
                    miim_wren   <= wr_q;
                    miim_rden   <= !wr_q;
                    cnt         <= '0;
                    err_q       <= 1'b0;
                    state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (miim_busy) begin
                        cnt   <= '0;
                        state <= S_WAIT_DONE;
                    end else if (cnt >= CW'(BUSY_WAIT - 1)) begin
                        state <= S_RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!miim_busy) begin
                        state <= S_RESP;
                    end else if (cnt >= CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid  <= ONE << win_q;
                    rsp_err    <= err_q;
                    rsp_rddata <= (!wr_q && !err_q) ? miim_rddata : 16'h0000;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
